// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path and datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_ALU_WB_R  = 4'd7,
    ST_EXEC_I    = 4'd8,
    ST_ALU_WB_I  = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_e;

  // One-hot instruction class produced by the opcode decoder.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic addi;
  } instr_class_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Opcode to one-hot instruction class; anything unsupported flags illegal.
module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  output instr_class_t class_o,
  output logic         illegal_o
);

  // Pure lookup; exactly one class bit or the illegal flag is set.
  always_comb begin
    class_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: class_o.rtype = 1'b1;
      OP_LW:    class_o.lw    = 1'b1;
      OP_SW:    class_o.sw    = 1'b1;
      OP_BEQ:   class_o.beq   = 1'b1;
      OP_J:     class_o.j     = 1'b1;
      OP_ADDI:  class_o.addi  = 1'b1;
      default:  illegal_o     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences the datapath,
// handshakes with the shared memory port and times out stalled accesses.
//
// state      | meaning
// FETCH      | read instruction at PC, IR <= mem, PC <= PC+4
// DECODE     | load A/B, precompute branch target into ALUOut
// MEM_ADDR   | ALUOut <= A + imm
// MEM_READ   | read data at ALUOut into MDR
// MEM_WB     | rt <= MDR
// MEM_WRITE  | write B to ALUOut address
// EXEC_R     | ALUOut <= A funct B
// ALU_WB_R   | rd <= ALUOut
// EXEC_I     | ALUOut <= A + imm
// ALU_WB_I   | rt <= ALUOut
// BRANCH     | compare A-B, PC <= ALUOut when zero
// JUMP       | PC <= jump target
//
// After a timeout one idle cycle (abort_q) is spent in FETCH with every
// output low so the memory sees the request drop before the retry.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] opcode_i,
  input  logic       alu_zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       mdr_we_o,
  output logic       ab_we_o,
  output logic       aluout_we_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic       rf_we_o,
  output logic       rf_dst_o,
  output logic       rf_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_op_o,
  output logic       mem_err_o,
  output logic [3:0] state_dbg_o
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e       state_q, state_d;
  logic [7:0]   wait_q, wait_d;
  logic         abort_q, abort_d;
  logic         is_sw_q, is_sw_d;

  instr_class_t cls;
  logic         op_illegal;
  logic         mem_access;
  logic         timed_out;

  logic         mem_req_c, mem_we_c, iord_c, ir_we_c, mdr_we_c, ab_we_c;
  logic         aluout_we_c, pc_en_c, rf_we_c, rf_dst_c, rf_src_c;
  logic         alu_src_a_c, illegal_c, mem_err_c;
  pc_src_e      pc_src_c;
  alu_src_b_e   alu_src_b_c;
  alu_op_e      alu_op_c;

  mips_opcode_decode u_dec (
    .opcode_i  (opcode_i),
    .class_o   (cls),
    .illegal_o (op_illegal)
  );

  assign mem_access = !abort_q && (state_q == ST_FETCH || state_q == ST_MEM_READ ||
                                   state_q == ST_MEM_WRITE);
  // mem_ready in the same cycle wins over the timeout.
  assign timed_out  = mem_access && !mem_ready_i && (wait_q == TMO);

  // Next-state, wait counter and per-state datapath controls.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    abort_d     = 1'b0;
    is_sw_d     = is_sw_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    iord_c      = 1'b0;
    ir_we_c     = 1'b0;
    mdr_we_c    = 1'b0;
    ab_we_c     = 1'b0;
    aluout_we_c = 1'b0;
    pc_en_c     = 1'b0;
    rf_we_c     = 1'b0;
    rf_dst_c    = 1'b0;
    rf_src_c    = 1'b0;
    alu_src_a_c = 1'b0;
    illegal_c   = 1'b0;
    mem_err_c   = 1'b0;
    pc_src_c    = PCSRC_ALU;
    alu_src_b_c = SRCB_B;
    alu_op_c    = ALU_ADD;

    if (mem_access && !mem_ready_i && !timed_out) begin
      wait_d = wait_q + 8'd1;
    end
    if (timed_out) begin
      mem_err_c = 1'b1;
      abort_d   = 1'b1;
    end

    if (abort_q) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_req_c   = 1'b1;
          alu_src_b_c = SRCB_FOUR;
          if (mem_ready_i) begin
            ir_we_c = 1'b1;
            pc_en_c = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          ab_we_c     = 1'b1;
          aluout_we_c = 1'b1;
          alu_src_b_c = SRCB_IMM_SH;
          is_sw_d     = cls.sw;
          if (cls.lw || cls.sw) state_d = ST_MEM_ADDR;
          else if (cls.rtype)   state_d = ST_EXEC_R;
          else if (cls.addi)    state_d = ST_EXEC_I;
          else if (cls.beq)     state_d = ST_BRANCH;
          else if (cls.j)       state_d = ST_JUMP;
          else begin
            illegal_c = op_illegal;
            state_d   = ST_FETCH;
          end
        end
        ST_MEM_ADDR: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
          aluout_we_c = 1'b1;
          state_d     = is_sw_q ? ST_MEM_WRITE : ST_MEM_READ;
        end
        ST_MEM_READ: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
          if (mem_ready_i) begin
            mdr_we_c = 1'b1;
            state_d  = ST_MEM_WB;
          end else if (timed_out) begin
            state_d = ST_FETCH;
          end
        end
        ST_MEM_WB: begin
          rf_we_c  = 1'b1;
          rf_src_c = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_MEM_WRITE: begin
          mem_req_c = 1'b1;
          mem_we_c  = 1'b1;
          iord_c    = 1'b1;
          if (mem_ready_i || timed_out) state_d = ST_FETCH;
        end
        ST_EXEC_R: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = ALU_FUNCT;
          aluout_we_c = 1'b1;
          state_d     = ST_ALU_WB_R;
        end
        ST_ALU_WB_R: begin
          rf_we_c  = 1'b1;
          rf_dst_c = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_EXEC_I: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
          aluout_we_c = 1'b1;
          state_d     = ST_ALU_WB_I;
        end
        ST_ALU_WB_I: begin
          rf_we_c = 1'b1;
          state_d = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = ALU_SUB;
          pc_src_c    = PCSRC_ALUOUT;
          pc_en_c     = alu_zero_i;
          state_d     = ST_FETCH;
        end
        ST_JUMP: begin
          pc_src_c = PCSRC_JUMP;
          pc_en_c  = 1'b1;
          state_d  = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State, wait counter and captured lw/sw selector with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      abort_q <= 1'b0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Every output is held low while reset is asserted.
  assign mem_req_o    = rst_n_i & mem_req_c;
  assign mem_we_o     = rst_n_i & mem_we_c;
  assign iord_o       = rst_n_i & iord_c;
  assign ir_we_o      = rst_n_i & ir_we_c;
  assign mdr_we_o     = rst_n_i & mdr_we_c;
  assign ab_we_o      = rst_n_i & ab_we_c;
  assign aluout_we_o  = rst_n_i & aluout_we_c;
  assign pc_en_o      = rst_n_i & pc_en_c;
  assign rf_we_o      = rst_n_i & rf_we_c;
  assign rf_dst_o     = rst_n_i & rf_dst_c;
  assign rf_src_o     = rst_n_i & rf_src_c;
  assign alu_src_a_o  = rst_n_i & alu_src_a_c;
  assign illegal_op_o = rst_n_i & illegal_c;
  assign mem_err_o    = rst_n_i & mem_err_c;
  assign pc_src_o     = rst_n_i ? pc_src_c    : 2'b00;
  assign alu_src_b_o  = rst_n_i ? alu_src_b_c : 2'b00;
  assign alu_op_o     = rst_n_i ? alu_op_c    : 2'b00;
  assign state_dbg_o  = rst_n_i ? state_q     : ST_FETCH;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus random instruction
// streams checked against a per-instruction summary model.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, mdr_we, ab_we, aluout_we, pc_en;
  logic [1:0] pc_src;
  logic       rf_we, rf_dst, rf_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       illegal_op, mem_err;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  wire [23:0] outs = {mem_req, mem_we, iord, ir_we, mdr_we, ab_we, aluout_we, pc_en,
                      pc_src, rf_we, rf_dst, rf_src, alu_src_a, alu_src_b, alu_op,
                      illegal_op, mem_err, state_dbg};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .opcode_i     (opcode),
    .alu_zero_i   (alu_zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .ir_we_o      (ir_we),
    .mdr_we_o     (mdr_we),
    .ab_we_o      (ab_we),
    .aluout_we_o  (aluout_we),
    .pc_en_o      (pc_en),
    .pc_src_o     (pc_src),
    .rf_we_o      (rf_we),
    .rf_dst_o     (rf_dst),
    .rf_src_o     (rf_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .illegal_op_o (illegal_op),
    .mem_err_o    (mem_err),
    .state_dbg_o  (state_dbg)
  );

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 6; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in a fresh FETCH at posedge+1.
  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode    = 6'($urandom);
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (outs !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_outs cycle %0d: got %h want 000000", i, outs);
      end
      tick();
    end
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, iord, state_dbg} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got req=%b iord=%b st=%0d want req=1 iord=0 st=0",
               mem_req, iord, state_dbg);
    end
    restart();
  endtask

  // Runs one instruction from a fresh FETCH. The model summarises what the
  // instruction must do (cycle count, enable pulse counts, write-back
  // selects, memory activity) from the instruction rules, independent of
  // the state machine structure.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                           input int dw, input string tag);
    bit is_r, is_lw, is_sw, is_beq, is_j, is_addi, ill, ls;
    int exp_cyc;
    int got[11], expv[11];
    string nm[11];
    int acc, wc;
    logic [1:0] br_src;
    logic we_src, we_dst;
    bit br_seen;
    is_r = (op == 6'h00); is_lw = (op == 6'h23); is_sw = (op == 6'h2B);
    is_beq = (op == 6'h04); is_j = (op == 6'h02); is_addi = (op == 6'h08);
    ill = !is_legal(op);
    ls  = is_lw || is_sw;
    exp_cyc = 1 + fw + (ill ? 1 : 1 + (is_lw ? 3 : (is_r || is_addi || is_sw) ? 2 : 1))
              + (ls ? dw : 0);
    nm = '{"ir_we", "pc_en", "rf_we", "mdr_we", "mem_req_cyc", "mem_we_cyc", "iord_cyc",
           "illegal", "mem_err", "ab_we", "rf_sel"};
    expv[0] = 1;
    expv[1] = 1 + ((is_beq && z) ? 1 : 0) + (is_j ? 1 : 0);
    expv[2] = (is_r || is_addi || is_lw) ? 1 : 0;
    expv[3] = is_lw ? 1 : 0;
    expv[4] = fw + 1 + (ls ? dw + 1 : 0);
    expv[5] = is_sw ? dw + 1 : 0;
    expv[6] = ls ? dw + 1 : 0;
    expv[7] = ill ? 1 : 0;
    expv[8] = 0;
    expv[9] = ill ? 1 : 1;
    expv[10] = is_lw ? 2 : (is_r ? 1 : 0);
    for (int k = 0; k < 11; k++) got[k] = 0;
    acc = 0; wc = 0; br_seen = 1'b0; br_src = 2'd0; we_src = 1'b0; we_dst = 1'b0;
    for (int c = 0; c < exp_cyc; c++) begin
      opcode   = op;
      alu_zero = z;
      if (mem_req) mem_ready = (wc == ((acc == 0) ? fw : dw));
      else         mem_ready = 1'($urandom);
      @(negedge clk);
      got[0] += int'(ir_we);
      got[1] += int'(pc_en);
      got[2] += int'(rf_we);
      got[3] += int'(mdr_we);
      got[4] += int'(mem_req);
      got[5] += int'(mem_req && mem_we);
      got[6] += int'(mem_req && iord);
      got[7] += int'(illegal_op);
      got[8] += int'(mem_err);
      got[9] += int'(ab_we);
      if (rf_we) begin we_src = rf_src; we_dst = rf_dst; end
      if (pc_en && !ir_we) begin br_seen = 1'b1; br_src = pc_src; end
      if (mem_req && mem_ready) begin acc++; wc = 0; end
      else if (mem_req) wc++;
      tick();
    end
    got[10] = {we_src, we_dst};
    for (int k = 0; k < 11; k++) begin
      n_checks++;
      if (got[k] !== expv[k]) begin
        n_fail++;
        $display("FAIL %s %s op=%h: got %0d want %0d", tag, nm[k], op, got[k], expv[k]);
      end
    end
    if ((is_beq && z) || is_j) begin
      n_checks++;
      if (!br_seen || br_src !== (is_j ? 2'd2 : 2'd1)) begin
        n_fail++;
        $display("FAIL %s pc_src op=%h: got %0d want %0d", tag, op, br_src,
                 is_j ? 2 : 1);
      end
    end
    n_checks++;
    if (state_dbg !== 4'd0 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_fetch op=%h: got st=%0d req=%b want st=0 req=1",
               tag, op, state_dbg, mem_req);
    end
  endtask

  task automatic test_lw_sequence();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode    = 6'h23;
    mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (state_dbg !== seq[c]) begin
        n_fail++;
        $display("FAIL lw_seq cycle %0d: got %0d want %0d", c, state_dbg, seq[c]);
      end
      if (c == 4) begin
        n_checks++;
        if ({rf_we, rf_src} !== 2'b11) begin
          n_fail++;
          $display("FAIL lw_wb: got rf_we=%b rf_src=%b want 1 1", rf_we, rf_src);
        end
      end
      tick();
    end
    n_checks++;
    if (state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_branch();
    run_instr(6'h04, 1'b1, 0, 0, "beq_taken");
    run_instr(6'h04, 1'b0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_sw_delay();
    run_instr(6'h2B, 1'b0, 0, 3, "sw_delay");
  endtask

  task automatic test_timeout();
    int err_cnt, err_at, en_cnt;
    logic req [6];
    logic [3:0] st [6];
    err_cnt = 0; err_at = -1; en_cnt = 0;
    opcode    = 6'h00;
    mem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_err) begin err_cnt++; err_at = c; end
      en_cnt += int'(ir_we) + int'(pc_en);
      req[c] = mem_req;
      st[c]  = state_dbg;
      tick();
    end
    n_checks++;
    if (err_cnt != 1 || err_at != TMO) begin
      n_fail++;
      $display("FAIL timeout_err: got count=%0d at=%0d want count=1 at=%0d",
               err_cnt, err_at, TMO);
    end
    n_checks++;
    if (en_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_enables: got %0d want 0", en_cnt);
    end
    n_checks++;
    if ({req[TMO], req[TMO+1], st[TMO+1]} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL timeout_drop: got req=%b,%b st=%0d want 1,0 st=0",
               req[TMO], req[TMO+1], st[TMO+1]);
    end
    n_checks++;
    if (mem_req !== 1'b1 || state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_refetch: got req=%b st=%0d want req=1 st=0", mem_req, state_dbg);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 1'b0, 0, 0, "illegal");
  endtask

  task automatic test_reset_mid_access();
    int mdr_cnt, req_cnt;
    mdr_cnt = 0; req_cnt = 0;
    opcode = 6'h23;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      if (c < 3) tick();
    end
    n_checks++;
    if ({state_dbg, mem_req, iord} !== {4'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_rst_setup: got st=%0d req=%b iord=%b want st=3 req=1 iord=1",
               state_dbg, mem_req, iord);
    end
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mdr_cnt += int'(mdr_we);
      req_cnt += int'(mem_req);
    end
    n_checks++;
    if (mdr_cnt != 0 || req_cnt != 0) begin
      n_fail++;
      $display("FAIL mid_rst_abandon: got mdr_we=%0d req=%0d want 0 0", mdr_cnt, req_cnt);
    end
    tick();
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({state_dbg, mem_req, iord, mdr_we} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst_release: got st=%0d req=%b iord=%b want st=0 req=1 iord=0",
               state_dbg, mem_req, iord);
    end
    restart();
  endtask

  task automatic test_random(input int n);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal_ops[k];
      end
      run_instr(op, 1'($urandom), $urandom_range(0, TMO), $urandom_range(0, TMO), "random");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_lw_sequence();
    test_branch();
    test_sw_delay();
    test_timeout();
    test_illegal();
    test_reset_mid_access();
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences the datapath state elements (PC, IR, MDR, A/B, ALUOut, register file) across fetch, decode, execute, memory and write-back steps. It handshakes with a single shared instruction/data memory port, and times out stalled accesses. It sits beside the datapath in the core top and drives every datapath enable and mux select.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for `mem_ready` per access; range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- alu_zero  in  1  ALU zero flag; used only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; qualified by `mem_req`.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_we, mdr_we, ab_we, aluout_we  out  1 each  datapath register enables.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- rf_we  out  1  register-file write enable.
- rf_dst  out  1  write register select: 0 = rt, 1 = rd.
- rf_src  out  1  write data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU operand B: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  2  ALU mode: 0 = add, 1 = sub, 2 = funct-decoded.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  one-cycle pulse on a memory timeout.
- state_dbg  out  4  current state encoding.

## Operation
- Supported opcodes:
  - 0x00 R-type
  - 0x23 lw
  - 0x2B sw
  - 0x04 beq
  - 0x02 j
  - 0x08 addi
- States and transitions:
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add, `pc_src`=0. Waits for `mem_ready`. In the `mem_ready` cycle: `ir_we`=1, `pc_en`=1, then go to DECODE.
  - DECODE: `ab_we`=1, `aluout_we`=1, `alu_src_a`=0, `alu_src_b`=3, `alu_op`=add (precomputes the branch target). Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type → EXEC_R
    - addi → EXEC_I
    - beq → BRANCH
    - j → JUMP
    - any other opcode → FETCH with `illegal_op`=1.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, add, `aluout_we`=1. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: `mem_req`=1, `iord`=1. On `mem_ready`: `mdr_we`=1, go to MEM_WB.
  - MEM_WB: `rf_we`=1, `rf_dst`=0, `rf_src`=1, then FETCH.
  - MEM_WRITE: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready` go to FETCH.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2, `aluout_we`=1, then ALU_WB_R.
  - ALU_WB_R: `rf_we`=1, `rf_dst`=1, `rf_src`=0, then FETCH.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=2, add, `aluout_we`=1, then ALU_WB_I.
  - ALU_WB_I: `rf_we`=1, `rf_dst`=0, `rf_src`=0, then FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=0, sub, `pc_src`=1, `pc_en`=`alu_zero`, then FETCH.
  - JUMP: `pc_src`=2, `pc_en`=1, then FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When it reaches MEM_TIMEOUT without `mem_ready`: `mem_err`=1, `mem_req` drops next cycle, go to FETCH with no register enables.
  - A timed-out FETCH re-fetches the same PC.
- Outputs not listed for a state are 0.
- The `mem_ready` cycle takes priority over timeout when both coincide.
- `mem_ready` outside an access state is ignored.

## Timing
- Outputs are combinational from the state register, gated by `mem_ready` and `alu_zero` where stated. No output register stage.
- Reset:
  - While `rst_n`=0 at a clock edge, the state becomes FETCH and the counter becomes 0.
  - While `rst_n` is low, every output is forced to 0 (`state_dbg`=FETCH encoding).
  - Reset mid-access abandons the access; `mem_req` drops in the cycle after the edge.
- Zero-wait latency, edges per instruction: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- `illegal_op` and `mem_err` are asserted exactly one cycle each.
- `mem_req`, `mem_we` and `iord` stay stable for the whole access.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - state encoding (4-bit)
  - `alu_op`, `alu_src_b` and `pc_src` encodings, also used by the datapath.
- Sub-module `mips_opcode_decode`: combinational, opcode → one-hot instruction class plus illegal flag.
- The FSM, wait counter and output decode live in `mips_multicycle_ctrl`.

## Test plan
- Reset with `rst_n`=0 for 3 cycles → all outputs 0. First cycle after release: `mem_req`=1, `iord`=0, `state_dbg`=FETCH.
- lw (opcode 0x23), `mem_ready` always 1 → state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. `rf_we`=1 with `rf_src`=1 on the 5th cycle. Back to FETCH on the 6th.
- beq with `alu_zero`=1, then again with `alu_zero`=0 → `pc_en`=1 and `pc_src`=1 in BRANCH for the first; `pc_en`=0 for the second. 3 cycles each.
- sw with `mem_ready` delayed 3 cycles in MEM_WRITE → `mem_req`=`mem_we`=1 held 4 cycles. Return to FETCH; no `rf_we`.
- MEM_TIMEOUT=4, `mem_ready` held 0 in FETCH → `mem_err` pulses after 4 wait cycles. No `ir_we` or `pc_en`; FETCH restarts.
- Opcode 0x3F → `illegal_op` pulse in DECODE, FETCH next. Then `rst_n`=0 asserted during MEM_READ of an lw → `mdr_we` never asserted; FETCH after release.
